// File: rtl/pipes_pkg.sv
// Shared pipeline types for the fetch stage: FSM states, the fetch-to-decode
// payload and the exception record that travels with it.
package pipes;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HALT    = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef logic [3:0] exc_cause_t;
  localparam exc_cause_t INSTR_ADDR_MISALIGNED = 4'd0;

  typedef struct packed {
    logic       valid;
    exc_cause_t cause;
    logic [63:0] tval;
  } ex_data_t;

  typedef struct packed {
    logic [31:0] instruction;
    logic [63:0] pc;
    ex_data_t    ex_data;
  } fetch_data_t;

endpackage

// File: rtl/fetch_unit_skid_buf.sv
// One-entry skid buffer catching a fetched word when the output register
// is held by a stalled decode stage.
module fetch_skid_buf
  import pipes::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  fetch_data_t load_data,
  output logic        full,
  output fetch_data_t data
);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      data <= load_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding bus requests, output register
// plus skid buffer toward decode. FETCH_MISALIGN_CHECK_EN enables the
// misaligned-pc exception and HALT state.
module fetch_unit
  import pipes::*;
#(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output fetch_data_t out_data
);

  fetch_state_t state_p0, state_nxt;
  logic [63:0]  pc_p0;
  logic [63:0]  req_addr_p0;
  logic         req_pend_p0;

  logic         consume, out_free, misaligned;
  logic         issue, resp, accept, raise_exc;
  logic         skid_full, skid_load, skid_drain;
  fetch_data_t  skid_data, new_data;

  assign consume  = out_valid && !stall;
  assign out_free = !out_valid || consume;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned = (pc_p0[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign issue = (state_p0 == FETCH) && !req_pend_p0 && !skid_full && out_free && !misaligned;

  // Once raised, the request is held from req_pend_p0 so the address cannot
  // follow a redirect-updated pc.
  assign ireq_valid = reset && (req_pend_p0 || issue);
  assign ireq_addr  = req_pend_p0 ? req_addr_p0 : pc_p0;

  assign resp      = ireq_valid && iresp_data_ok;
  assign accept    = resp && (state_p0 == FETCH) && !redirect;
  assign raise_exc = (state_p0 == FETCH) && !req_pend_p0 && !skid_full && out_free
                     && misaligned && !redirect;

  assign skid_load  = accept && !out_free;
  assign skid_drain = consume && skid_full;

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      FETCH: begin
        if (redirect) begin
          state_nxt = (ireq_valid && !iresp_data_ok) ? DISCARD : FETCH;
        end else if (raise_exc) begin
          state_nxt = HALT;
        end
      end
      DISCARD: begin
        if (resp) begin
          state_nxt = FETCH;
        end
      end
      HALT: begin
        if (redirect) begin
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    new_data    = '0;
    new_data.pc = pc_p0;
    if (raise_exc) begin
      new_data.instruction   = NOP_INSTR;
      new_data.ex_data.valid = 1'b1;
      new_data.ex_data.cause = INSTR_ADDR_MISALIGNED;
      new_data.ex_data.tval  = pc_p0;
    end else begin
      new_data.instruction = iresp_data;
    end
  end

  // p0: fetch control -- state, pc, outstanding request
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_p0    <= FETCH;
      pc_p0       <= RESET_PC;
      req_pend_p0 <= 1'b0;
    end else begin
      state_p0    <= state_nxt;
      req_pend_p0 <= ireq_valid && !iresp_data_ok;
      if (redirect) begin
        pc_p0 <= redirect_pc;
      end else if (accept) begin
        pc_p0 <= pc_p0 + 64'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      req_addr_p0 <= pc_p0;
    end
  end

  // p1: output register toward decode; a parked skid entry is older than
  // any new response, so it drains first
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (redirect) begin
      out_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_full) begin
        out_valid <= 1'b1;
        out_data  <= skid_data;
      end else if (accept || raise_exc) begin
        out_valid <= 1'b1;
        out_data  <= new_data;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  fetch_skid_buf u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (skid_load),
    .drain     (skid_drain),
    .clear     (redirect),
    .load_data (new_data),
    .full      (skid_full),
    .data      (skid_data)
  );

endmodule
